// File: rtl/updown_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_pkg
// Brief    : Shared types and constants for the up/down count decoder.
// Revision : 1.0 - initial release
// ============================================================================
package updown_pkg;

  // Decoder lock state: no sample yet, sampling without direction, locked up/down.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    UP   = 2'd2,
    DOWN = 2'd3
  } state_t;

  // Classification of one sample relative to the previous sample.
  typedef enum logic [1:0] {
    UP_STEP = 2'd0,
    DN_STEP = 2'd1,
    HOLD    = 2'd2,
    JUMP    = 2'd3
  } step_t;

  // Direction encoding matches the counter's mode input.
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // True for the two locked states.
  function automatic logic is_locked(input state_t s);
    return (s == UP) || (s == DOWN);
  endfunction

endpackage : updown_pkg
`default_nettype wire

// File: rtl/updown_step_classify.sv
`default_nettype none
// ============================================================================
// Module   : updown_step_classify
// Brief    : Combinational step classifier: compares a new sample with the
//            previous one modulo 2^WIDTH and reports step class and wrap.
// Revision : 1.0 - initial release
// ============================================================================
module updown_step_classify
  import updown_pkg::*;
#(
  // Must be >= 2; with one bit +1 and -1 cannot be told apart.
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] q_in,
  output step_t            step,
  output logic             wrap
);

  logic [WIDTH-1:0] delta;

  // Modular difference; the subtraction naturally wraps at 2^WIDTH.
  always_comb begin
    delta = q_in - prev;
    step  = JUMP;
    if (delta == WIDTH'(1)) begin
      step = UP_STEP;
    end else if (delta == {WIDTH{1'b1}}) begin
      step = DN_STEP;
    end else if (delta == '0) begin
      step = HOLD;
    end
  end

  // Wrap is a legal single step across the max/zero boundary.
  always_comb begin
    wrap = ((step == UP_STEP) && (prev == {WIDTH{1'b1}})) ||
           ((step == DN_STEP) && (prev == '0));
  end

endmodule : updown_step_classify
`default_nettype wire

// File: rtl/updown_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : updown_count_decoder
// Brief    : Monitors an up/down counter's output stream, recovers the count
//            direction and flags wraps, reversals and illegal jumps, with
//            saturating error and run-length counters. All outputs registered.
// Revision : 1.0 - initial release
// ============================================================================
module updown_count_decoder
  import updown_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_valid,
  output logic             dir,
  output logic             dir_valid,
  output logic             wrap,
  output logic             dir_change,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count,
  output logic [RUN_W-1:0] run_len
);

  state_t           state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  step_t            step;
  logic             step_wrap;

  logic             dir_n;
  logic             wrap_n;
  logic             dir_change_n;
  logic             step_err_n;
  logic [ERR_W-1:0] err_count_n;
  logic [RUN_W-1:0] run_len_n;
  logic [RUN_W-1:0] run_inc;

  updown_step_classify #(
    .WIDTH (WIDTH)
  ) u_classify (
    .prev (prev),
    .q_in (q_in),
    .step (step),
    .wrap (step_wrap)
  );

  // Saturating run-length increment used while continuing in one direction.
  always_comb begin
    run_inc = (run_len == {RUN_W{1'b1}}) ? run_len : run_len + RUN_W'(1);
  end

  // Next-state and next-output logic; everything holds unless a sample arrives.
  always_comb begin
    state_n      = state;
    prev_n       = prev;
    dir_n        = dir;
    wrap_n       = 1'b0;
    dir_change_n = 1'b0;
    step_err_n   = 1'b0;
    err_count_n  = err_count;
    run_len_n    = run_len;

    if (q_valid) begin
      prev_n = q_in;

      // The first sample has no predecessor, so it cannot wrap or err.
      if (state != IDLE) begin
        wrap_n = step_wrap;
      end

      case (state)
        IDLE: begin
          state_n = ACQ;
        end

        ACQ: begin
          case (step)
            UP_STEP: begin
              state_n   = UP;
              dir_n     = DIR_UP;
              run_len_n = RUN_W'(1);
            end
            DN_STEP: begin
              state_n   = DOWN;
              dir_n     = DIR_DN;
              run_len_n = RUN_W'(1);
            end
            HOLD: begin
              state_n = ACQ;
            end
            default: begin
              step_err_n = 1'b1;
            end
          endcase
        end

        UP: begin
          case (step)
            UP_STEP: begin
              run_len_n = run_inc;
            end
            DN_STEP: begin
              state_n      = DOWN;
              dir_n        = DIR_DN;
              dir_change_n = 1'b1;
              run_len_n    = RUN_W'(1);
            end
            HOLD: begin
              state_n = UP;
            end
            default: begin
              state_n    = ACQ;
              step_err_n = 1'b1;
              run_len_n  = '0;
            end
          endcase
        end

        DOWN: begin
          case (step)
            DN_STEP: begin
              run_len_n = run_inc;
            end
            UP_STEP: begin
              state_n      = UP;
              dir_n        = DIR_UP;
              dir_change_n = 1'b1;
              run_len_n    = RUN_W'(1);
            end
            HOLD: begin
              state_n = DOWN;
            end
            default: begin
              state_n    = ACQ;
              step_err_n = 1'b1;
              run_len_n  = '0;
            end
          endcase
        end

        default: begin
          state_n = IDLE;
        end
      endcase

      if (step_err_n && (err_count != {ERR_W{1'b1}})) begin
        err_count_n = err_count + ERR_W'(1);
      end
    end
  end

  // State, history and registered outputs; reset discards all history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prev       <= '0;
      dir        <= 1'b0;
      dir_valid  <= 1'b0;
      wrap       <= 1'b0;
      dir_change <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
      run_len    <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      dir        <= dir_n;
      dir_valid  <= is_locked(state_n);
      wrap       <= wrap_n;
      dir_change <= dir_change_n;
      step_err   <= step_err_n;
      err_count  <= err_count_n;
      run_len    <= run_len_n;
    end
  end

endmodule : updown_count_decoder
`default_nettype wire

// File: tb/tb_updown_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_count_decoder
// Brief    : Directed self-checking bench for updown_count_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_count_decoder;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       q_valid;
  logic       dir;
  logic       dir_valid;
  logic       wrap;
  logic       dir_change;
  logic       step_err;
  logic [7:0] err_count;
  logic [7:0] run_len;

  int tests_run;
  int tests_failed;

  updown_count_decoder #(
    .WIDTH (4),
    .ERR_W (8),
    .RUN_W (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .q_valid    (q_valid),
    .dir        (dir),
    .dir_valid  (dir_valid),
    .wrap       (wrap),
    .dir_change (dir_change),
    .step_err   (step_err),
    .err_count  (err_count),
    .run_len    (run_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flags packed as {dir, dir_valid, wrap, dir_change, step_err}.
  function automatic logic [4:0] flags();
    return {dir, dir_valid, wrap, dir_change, step_err};
  endfunction

  task automatic do_reset();
    reset   = 1'b1;
    q_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Present one valid sample for one edge; outputs are sampled 1 unit after.
  task automatic send(input logic [3:0] v);
    q_in    = v;
    q_valid = 1'b1;
    @(posedge clk); #1;
    q_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (flags() !== 5'b00000 || run_len !== 8'd0 || err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset: flags=%b run=%0d err=%0d want flags=00000 run=0 err=0", flags(), run_len, err_count);
    end
  endtask

  task automatic test_up_lock();
    do_reset();
    send(4'd0);
    tests_run++;
    if (flags() !== 5'b00000 || run_len !== 8'd0) begin
      tests_failed++;
      $display("FAIL up_lock_s0: flags=%b run=%0d want flags=00000 run=0", flags(), run_len);
    end
    send(4'd1);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL up_lock_s1: flags=%b run=%0d want flags=11000 run=1", flags(), run_len);
    end
    send(4'd2);
    send(4'd3);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd3) begin
      tests_failed++;
      $display("FAIL up_lock_s3: flags=%b run=%0d want flags=11000 run=3", flags(), run_len);
    end
  endtask

  task automatic test_up_wrap();
    do_reset();
    send(4'd14);
    send(4'd15);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL up_wrap_15: flags=%b run=%0d want flags=11000 run=1", flags(), run_len);
    end
    send(4'd0);
    tests_run++;
    if (flags() !== 5'b11100 || run_len !== 8'd2) begin
      tests_failed++;
      $display("FAIL up_wrap_0: flags=%b run=%0d want flags=11100 run=2", flags(), run_len);
    end
    send(4'd1);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd3) begin
      tests_failed++;
      $display("FAIL up_wrap_1: flags=%b run=%0d want flags=11000 run=3", flags(), run_len);
    end
  endtask

  task automatic test_down_wrap();
    do_reset();
    send(4'd0);
    send(4'd15);
    tests_run++;
    if (flags() !== 5'b01100 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL down_wrap_15: flags=%b run=%0d want flags=01100 run=1", flags(), run_len);
    end
    send(4'd14);
    tests_run++;
    if (flags() !== 5'b01000 || run_len !== 8'd2) begin
      tests_failed++;
      $display("FAIL down_wrap_14: flags=%b run=%0d want flags=01000 run=2", flags(), run_len);
    end
  endtask

  task automatic test_reverse();
    do_reset();
    send(4'd5);
    send(4'd6);
    send(4'd7);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd2) begin
      tests_failed++;
      $display("FAIL reverse_7: flags=%b run=%0d want flags=11000 run=2", flags(), run_len);
    end
    send(4'd6);
    tests_run++;
    if (flags() !== 5'b01010 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL reverse_6: flags=%b run=%0d want flags=01010 run=1", flags(), run_len);
    end
    send(4'd5);
    tests_run++;
    if (flags() !== 5'b01000 || run_len !== 8'd2) begin
      tests_failed++;
      $display("FAIL reverse_5: flags=%b run=%0d want flags=01000 run=2", flags(), run_len);
    end
    send(4'd4);
    tests_run++;
    if (flags() !== 5'b01000 || run_len !== 8'd3) begin
      tests_failed++;
      $display("FAIL reverse_4: flags=%b run=%0d want flags=01000 run=3", flags(), run_len);
    end
  endtask

  task automatic test_jump();
    do_reset();
    send(4'd9);
    send(4'd8);
    tests_run++;
    if (flags() !== 5'b01000 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL jump_8: flags=%b run=%0d want flags=01000 run=1", flags(), run_len);
    end
    send(4'd3);
    tests_run++;
    if (flags() !== 5'b00001 || run_len !== 8'd0 || err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL jump_3: flags=%b run=%0d err=%0d want flags=00001 run=0 err=1", flags(), run_len, err_count);
    end
    send(4'd4);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd1 || err_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL jump_4: flags=%b run=%0d err=%0d want flags=11000 run=1 err=1", flags(), run_len, err_count);
    end
  endtask

  task automatic test_hold_gaps();
    do_reset();
    send(4'd2);
    send(4'd3);
    idle(3);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL hold_gap: flags=%b run=%0d want flags=11000 run=1", flags(), run_len);
    end
    send(4'd3);
    idle(2);
    send(4'd3);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd1 || err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL hold_repeat: flags=%b run=%0d err=%0d want flags=11000 run=1 err=0", flags(), run_len, err_count);
    end
    send(4'd4);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd2) begin
      tests_failed++;
      $display("FAIL hold_resume: flags=%b run=%0d want flags=11000 run=2", flags(), run_len);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(4'd3);
    send(4'd4);
    q_in    = 4'd5;
    q_valid = 1'b1;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    q_valid = 1'b0;
    tests_run++;
    if (flags() !== 5'b00000 || run_len !== 8'd0 || err_count !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: flags=%b run=%0d err=%0d want flags=00000 run=0 err=0", flags(), run_len, err_count);
    end
    send(4'd6);
    tests_run++;
    if (flags() !== 5'b00000 || run_len !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_6: flags=%b run=%0d want flags=00000 run=0", flags(), run_len);
    end
    send(4'd7);
    tests_run++;
    if (flags() !== 5'b11000 || run_len !== 8'd1) begin
      tests_failed++;
      $display("FAIL reset_mid_7: flags=%b run=%0d want flags=11000 run=1", flags(), run_len);
    end
  endtask

  task automatic test_err_saturate();
    do_reset();
    send(4'd0);
    for (int i = 1; i <= 300; i++) begin
      send(i[0] ? 4'd8 : 4'd0);
      if (i == 254) begin
        tests_run++;
        if (err_count !== 8'd254 || step_err !== 1'b1) begin
          tests_failed++;
          $display("FAIL err_254: err=%0d step_err=%b want err=254 step_err=1", err_count, step_err);
        end
      end
    end
    tests_run++;
    if (err_count !== 8'd255 || step_err !== 1'b1 || dir_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_sat: err=%0d step_err=%b dv=%b want err=255 step_err=1 dv=0", err_count, step_err, dir_valid);
    end
  endtask

  task automatic test_run_saturate();
    do_reset();
    send(4'd0);
    for (int i = 1; i <= 260; i++) begin
      send(4'(i));
      if (i == 254) begin
        tests_run++;
        if (run_len !== 8'd254) begin
          tests_failed++;
          $display("FAIL run_254: run=%0d want 254", run_len);
        end
      end
    end
    tests_run++;
    if (run_len !== 8'd255 || flags() !== 5'b11000) begin
      tests_failed++;
      $display("FAIL run_sat: run=%0d flags=%b want run=255 flags=11000", run_len, flags());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    q_valid      = 1'b0;
    q_in         = 4'd0;
    repeat (2) @(posedge clk);
    #1;

    test_reset();
    test_up_lock();
    test_up_wrap();
    test_down_wrap();
    test_reverse();
    test_jump();
    test_hold_gaps();
    test_reset_mid();
    test_err_saturate();
    test_run_saturate();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_updown_count_decoder
`default_nettype wire

// File: doc/updown_count_decoder.md
Name: updown_count_decoder

Overview:
- Receive-side companion to the team's 4-bit up/down counter.
- Samples the counter's q stream and recovers the counting direction (mode: 1 = up, 0 = down).
- Flags wrap-around, direction reversals and illegal steps (jumps); keeps saturating error and run-length counts.
- Sits downstream of any up/down counter as a monitor and decoder; drives nothing back to the counter.

Parameters:
WIDTH, 4, width of sampled count; must be >= 2 (for 1 bit, +1 and -1 are indistinguishable)
ERR_W, 8, width of saturating illegal-step counter
RUN_W, 8, width of saturating same-direction run-length counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
q_in  input  WIDTH  sampled counter value
q_valid  input  1  q_in is a new sample this cycle
dir  output  1  decoded direction: 1 = up, 0 = down; meaningful only when dir_valid = 1
dir_valid  output  1  direction locked (state UP or DOWN)
wrap  output  1  1-cycle pulse: step crossed max->0 (up) or 0->max (down)
dir_change  output  1  1-cycle pulse: locked direction reversed
step_err  output  1  1-cycle pulse: illegal step (jump)
err_count  output  ERR_W  saturating count of step_err events
run_len  output  RUN_W  saturating count of consecutive steps in the current locked direction

Behaviour:
- Single clock domain. All outputs are registered.
- Reset: when reset = 1 at a rising edge:
  - state <= IDLE; prev sample <= 0.
  - All outputs <= 0.
  - Reset overrides q_valid in the same cycle. Reset mid-stream discards history.
- Cycles with q_valid = 0: state, prev, dir, dir_valid, err_count and run_len hold; pulse outputs (wrap, dir_change, step_err) are 0.
- Latency: every output reflects a sample 1 cycle after the edge at which q_valid = 1 was captured.
- Step classification, for each valid sample when prev exists:
  - delta = (q_in - prev) mod 2^WIDTH.
  - UP_STEP: delta = 1.
  - DN_STEP: delta = 2^WIDTH - 1.
  - HOLD: delta = 0.
  - JUMP: any other value.
  - prev <= q_in on every valid sample, in every state.
- States and transitions:
  - IDLE: valid -> ACQ. No pulses. Only the first sample is stored.
  - ACQ (no direction yet):
    - UP_STEP -> UP, run_len <= 1.
    - DN_STEP -> DOWN, run_len <= 1.
    - HOLD -> stay in ACQ.
    - JUMP -> stay in ACQ, step_err pulse.
  - UP:
    - UP_STEP -> stay in UP, run_len + 1 (saturating).
    - DN_STEP -> DOWN, dir_change pulse, run_len <= 1.
    - HOLD -> stay in UP, run_len unchanged.
    - JUMP -> ACQ, step_err pulse, run_len <= 0.
  - DOWN: mirror of UP.
- dir_valid = 1 exactly when state is UP or DOWN. dir = 1 in UP, 0 in DOWN.
  - In IDLE/ACQ, dir keeps its last value; it is not a don't-care for the bench, which checks it held.
- wrap pulses on any UP_STEP with prev = all-ones, or any DN_STEP with prev = 0, in any state including ACQ.
  - Can coincide with dir_change in the same cycle.
- err_count increments on each step_err and saturates at 2^ERR_W - 1.
- run_len saturates at 2^RUN_W - 1.
- JUMP in ACQ does not change run_len, which is already 0.

Decomposition:
- Shared package updown_pkg:
  - State enum: IDLE, ACQ, UP, DOWN (2 bits).
  - Step-class enum: UP_STEP, DN_STEP, HOLD, JUMP.
  - Direction constants DIR_UP = 1, DIR_DN = 0, matching the counter's mode encoding.
- One natural sub-module, updown_step_classify: combinational; takes prev and q_in, returns the step class and the wrap flag.
- The FSM and the counters stay in the top module.

Test Plan:
- Reset, then samples 0,1,2,3 with q_valid every cycle -> dir_valid = 1 and dir = 1 one cycle after sample 1; run_len = 3 after sample 3; no pulses.
- Up stream 14,15,0,1 -> wrap = 1 for exactly one cycle (the cycle after sample 0 is registered); dir stays 1; run_len = 3.
- Up stream 5,6,7 then 6 -> dir_change pulse, dir = 0, run_len = 1; then 5,4 -> run_len = 3.
- Down stream 9,8 then 3 -> step_err pulse, err_count = 1, dir_valid = 0 (state ACQ), run_len = 0; then 4 -> UP, dir = 1, dir_valid = 1.
- Up stream 2,3 with q_valid gaps and repeated 3s (HOLD) -> no pulses, run_len held at 1, dir_valid held.
- Assert reset in the cycle where sample 5 follows 4 in an up stream -> next cycle all outputs 0, state IDLE; the following sample 6 only enters ACQ.
- 300 consecutive JUMP samples (alternating 0 and 8) -> err_count saturates at 255.
